// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin front end for an I2C core: grants one requester,
// issues its command for one cycle, waits for completion or timeout, then acks.
module i2c_req_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int CMDW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic [CMDW-1:0] cmd0,
    input  logic [31:0]     wdata0,
    input  logic            req1,
    input  logic [CMDW-1:0] cmd1,
    input  logic [31:0]     wdata1,
    output logic            ack0,
    output logic            ack1,
    output logic [31:0]     rdata,
    output logic            err,
    output logic            busy,
    output logic            owner,
    output logic [31:0]     core_cmd,
    output logic [31:0]     core_data_in,
    input  logic [31:0]     core_data_out,
    input  logic            core_done
);

    localparam int CNTW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic            ptr_reg;
    logic            owner_reg;
    logic [CMDW-1:0] cmd_reg;
    logic [31:0]     wdata_reg;
    logic [31:0]     rdata_reg;
    logic            err_reg;
    logic [CNTW-1:0] cnt_reg;

    logic            any_req;
    logic            grant;
    logic            timeout_hit;

    assign any_req     = req0 | req1;
    // Contention goes to the pointer; a lone requester wins outright.
    assign grant       = (req0 && req1) ? ptr_reg : req1;
    assign timeout_hit = (cnt_reg == CNTW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = (cmd_reg == '0) ? RESP : WAIT;
            WAIT:    if (core_done || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latched request, response capture, timeout counter, pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= 1'b0;
            owner_reg <= 1'b0;
            cmd_reg   <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (any_req) begin
                        owner_reg <= grant;
                        cmd_reg   <= grant ? cmd1 : cmd0;
                        wdata_reg <= grant ? wdata1 : wdata0;
                        rdata_reg <= '0;
                        err_reg   <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt_reg <= '0;
                    if (cmd_reg == '0) begin
                        err_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (core_done) begin
                        rdata_reg <= core_data_out;
                        err_reg   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNTW'(1);
                    end
                end
                RESP: begin
                    cnt_reg <= '0;
                    ptr_reg <= ~owner_reg;
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

    // Output decode
    always_comb begin
        ack0         = (state_reg == RESP) && !owner_reg;
        ack1         = (state_reg == RESP) && owner_reg;
        busy         = (state_reg != IDLE);
        owner        = owner_reg;
        rdata        = rdata_reg;
        err          = err_reg;
        core_cmd     = (state_reg == ISSUE) ? 32'(cmd_reg) : 32'd0;
        core_data_in = (state_reg != IDLE) ? wdata_reg : 32'd0;
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: single transfer, arbitration, timeout,
// zero command and mid-transaction reset, each checked cycle by cycle.
module tb_i2c_req_arbiter;

    localparam int CMDW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0 = 1'b0, req1 = 1'b0;
    logic [CMDW-1:0] cmd0 = '0, cmd1 = '0;
    logic [31:0]     wdata0 = '0, wdata1 = '0;
    logic            ack0, ack1, err, busy, owner;
    logic [31:0]     rdata, core_cmd, core_data_in;
    logic [31:0]     core_data_out = '0;
    logic            core_done = 1'b0;

    int total = 0;
    int bad   = 0;

    i2c_req_arbiter #(.TIMEOUT(8), .CMDW(CMDW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .cmd0(cmd0), .wdata0(wdata0),
        .req1(req1), .cmd1(cmd1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
        .busy(busy), .owner(owner),
        .core_cmd(core_cmd), .core_data_in(core_data_in),
        .core_data_out(core_data_out), .core_done(core_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 0; req1 = 0; core_done = 0; core_data_out = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if ({ack0, ack1, err, busy, owner, rdata, core_cmd, core_data_in} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ack=%b%b err=%b busy=%b owner=%b rdata=%h cmd=%h din=%h want all zero",
                     ack0, ack1, err, busy, owner, rdata, core_cmd, core_data_in);
        end
        do_reset();
    endtask

    // req0 cmd=1, core_done at cycle 5 -> ack0 at cycle 6
    task automatic test_single();
        logic [31:0] e_cmd;
        logic        e_ack0, e_busy;
        for (int c = 0; c < 8; c++) begin
            req0 = (c <= 6); cmd0 = 3'd1; wdata0 = 32'h5AA5;
            core_done = (c == 5);
            core_data_out = (c == 5) ? 32'h00C3 : 32'hDEAD;
            e_cmd  = (c == 1) ? 32'd1 : 32'd0;
            e_ack0 = (c == 6);
            e_busy = (c >= 1 && c <= 6);
            @(negedge clk);
            total++;
            if ({ack0, ack1, busy, core_cmd} !== {e_ack0, 1'b0, e_busy, e_cmd}) begin
                bad++;
                $display("FAIL single_c%0d got ack=%b%b busy=%b cmd=%h want ack=%b0 busy=%b cmd=%h",
                         c, ack0, ack1, busy, core_cmd, e_ack0, e_busy, e_cmd);
            end
            if (e_busy) begin
                total++;
                if ({owner, core_data_in} !== {1'b0, 32'h5AA5}) begin
                    bad++;
                    $display("FAIL single_owner_c%0d got owner=%b din=%h want 0 00005aa5", c, owner, core_data_in);
                end
            end
            if (c == 6) begin
                total++;
                if ({rdata, err} !== {32'h00C3, 1'b0}) begin
                    bad++;
                    $display("FAIL single_resp got rdata=%h err=%b want 000000c3 0", rdata, err);
                end
                $display("txn single owner=%0d rdata=%h err=%0d", owner, rdata, err);
            end
            step();
        end
        req0 = 0; core_done = 0;
    endtask

    // both request after reset: 0 first, then 1; non-owner inputs change mid-flight
    task automatic test_arbitration();
        logic [31:0] e_cmd, e_rd, e_din;
        logic        e_ack0, e_ack1, e_busy, e_own;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req0 = (c <= 3); req1 = (c <= 7);
            cmd0 = (c >= 5) ? 3'd7 : 3'd2; wdata0 = (c >= 5) ? 32'hFFFF : 32'hA0;
            cmd1 = 3'd3; wdata1 = 32'hB1;
            core_done = (c == 2) || (c == 6);
            core_data_out = (c == 2) ? 32'h11 : (c == 6) ? 32'h22 : 32'h0;
            e_cmd  = (c == 1) ? 32'd2 : (c == 5) ? 32'd3 : 32'd0;
            e_ack0 = (c == 3);
            e_ack1 = (c == 7);
            e_busy = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
            e_own  = (c >= 5);
            e_din  = e_own ? 32'hB1 : 32'hA0;
            e_rd   = (c == 3) ? 32'h11 : 32'h22;
            @(negedge clk);
            total++;
            if ({ack0, ack1, busy, core_cmd} !== {e_ack0, e_ack1, e_busy, e_cmd}) begin
                bad++;
                $display("FAIL arb_c%0d got ack=%b%b busy=%b cmd=%h want ack=%b%b busy=%b cmd=%h",
                         c, ack0, ack1, busy, core_cmd, e_ack0, e_ack1, e_busy, e_cmd);
            end
            if (e_busy) begin
                total++;
                if ({owner, core_data_in} !== {e_own, e_din}) begin
                    bad++;
                    $display("FAIL arb_owner_c%0d got owner=%b din=%h want %b %h", c, owner, core_data_in, e_own, e_din);
                end
            end
            if (e_ack0 || e_ack1) begin
                total++;
                if ({rdata, err} !== {e_rd, 1'b0}) begin
                    bad++;
                    $display("FAIL arb_resp_c%0d got rdata=%h err=%b want %h 0", c, rdata, err, e_rd);
                end
                $display("txn arb owner=%0d rdata=%h err=%0d", owner, rdata, err);
            end
            step();
        end
        req0 = 0; req1 = 0; core_done = 0;
    endtask

    // no completion (early core_done in ISSUE is ignored): ack 8 cycles after WAIT entry
    task automatic test_timeout();
        logic e_ack0, e_busy;
        for (int c = 0; c < 12; c++) begin
            req0 = (c <= 10); cmd0 = 3'd5; wdata0 = 32'h55;
            core_done = (c == 1);
            core_data_out = 32'h99;
            e_ack0 = (c == 10);
            e_busy = (c >= 1 && c <= 10);
            @(negedge clk);
            total++;
            if ({ack0, ack1, busy} !== {e_ack0, 1'b0, e_busy}) begin
                bad++;
                $display("FAIL timeout_c%0d got ack=%b%b busy=%b want ack=%b0 busy=%b", c, ack0, ack1, busy, e_ack0, e_busy);
            end
            if (c == 10) begin
                total++;
                if ({rdata, err} !== {32'h0, 1'b1}) begin
                    bad++;
                    $display("FAIL timeout_resp got rdata=%h err=%b want 00000000 1", rdata, err);
                end
                $display("txn timeout owner=%0d rdata=%h err=%0d", owner, rdata, err);
            end
            step();
        end
        req0 = 0; core_done = 0;
    endtask

    // core_done on the last WAIT cycle beats the timeout
    task automatic test_done_at_timeout();
        logic e_ack0;
        for (int c = 0; c < 12; c++) begin
            req0 = (c <= 10); cmd0 = 3'd4; wdata0 = 32'h44;
            core_done = (c == 9);
            core_data_out = (c == 9) ? 32'h3C : 32'h0;
            e_ack0 = (c == 10);
            @(negedge clk);
            total++;
            if ({ack0, ack1} !== {e_ack0, 1'b0}) begin
                bad++;
                $display("FAIL edge_c%0d got ack=%b%b want %b0", c, ack0, ack1, e_ack0);
            end
            if (c == 10) begin
                total++;
                if ({rdata, err} !== {32'h3C, 1'b0}) begin
                    bad++;
                    $display("FAIL edge_resp got rdata=%h err=%b want 0000003c 0", rdata, err);
                end
                $display("txn edge owner=%0d rdata=%h err=%0d", owner, rdata, err);
            end
            step();
        end
        req0 = 0; core_done = 0;
    endtask

    // cmd1=0: straight to RESP with err, core_cmd stays zero
    task automatic test_zero_cmd();
        logic e_ack1, e_busy;
        for (int c = 0; c < 5; c++) begin
            req1 = (c <= 2); cmd1 = 3'd0; wdata1 = 32'h77;
            e_ack1 = (c == 2);
            e_busy = (c == 1 || c == 2);
            @(negedge clk);
            total++;
            if ({ack0, ack1, busy, core_cmd} !== {1'b0, e_ack1, e_busy, 32'd0}) begin
                bad++;
                $display("FAIL zero_c%0d got ack=%b%b busy=%b cmd=%h want ack=0%b busy=%b cmd=00000000",
                         c, ack0, ack1, busy, core_cmd, e_ack1, e_busy);
            end
            if (c == 2) begin
                total++;
                if ({owner, err, core_data_in} !== {1'b1, 1'b1, 32'h77}) begin
                    bad++;
                    $display("FAIL zero_resp got owner=%b err=%b din=%h want 1 1 00000077", owner, err, core_data_in);
                end
                $display("txn zero owner=%0d rdata=%h err=%0d", owner, rdata, err);
            end
            step();
        end
        req1 = 0;
    endtask

    // reset in WAIT clears outputs at once; no stale ack; next request works
    task automatic test_reset_mid();
        logic [31:0] e_cmd;
        logic        e_ack0;
        for (int c = 0; c < 4; c++) begin
            req0 = 1'b1; cmd0 = 3'd1; wdata0 = 32'h1234;
            step();
        end
        total++;
        if ({busy, core_data_in} !== {1'b1, 32'h1234}) begin
            bad++;
            $display("FAIL rmid_pre got busy=%b din=%h want 1 00001234", busy, core_data_in);
        end
        rst = 1'b1; req0 = 1'b0;
        #1;
        total++;
        if ({ack0, ack1, err, busy, owner, rdata, core_cmd, core_data_in} !== '0) begin
            bad++;
            $display("FAIL rmid_outputs got ack=%b%b err=%b busy=%b owner=%b rdata=%h cmd=%h din=%h want all zero",
                     ack0, ack1, err, busy, owner, rdata, core_cmd, core_data_in);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            core_done = (c == 2);
            core_data_out = 32'hEE;
            @(negedge clk);
            total++;
            if ({ack0, ack1, busy} !== 3'b000) begin
                bad++;
                $display("FAIL rmid_idle_c%0d got ack=%b%b busy=%b want 000", c, ack0, ack1, busy);
            end
            step();
        end
        core_done = 0;
        for (int c = 0; c < 6; c++) begin
            req0 = (c <= 4); cmd0 = 3'd6; wdata0 = 32'h4321;
            core_done = (c == 3);
            core_data_out = (c == 3) ? 32'h77 : 32'h0;
            e_cmd  = (c == 1) ? 32'd6 : 32'd0;
            e_ack0 = (c == 4);
            @(negedge clk);
            total++;
            if ({ack0, ack1, core_cmd} !== {e_ack0, 1'b0, e_cmd}) begin
                bad++;
                $display("FAIL rmid_after_c%0d got ack=%b%b cmd=%h want %b0 %h", c, ack0, ack1, core_cmd, e_ack0, e_cmd);
            end
            if (c == 4) begin
                total++;
                if ({rdata, err} !== {32'h77, 1'b0}) begin
                    bad++;
                    $display("FAIL rmid_resp got rdata=%h err=%b want 00000077 0", rdata, err);
                end
                $display("txn after_reset owner=%0d rdata=%h err=%0d", owner, rdata, err);
            end
            step();
        end
        req0 = 0; core_done = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_timeout();
        test_done_at_timeout();
        test_zero_cmd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
